// File: rtl/boron_key_schedule_if.sv
// Round-key schedule bus between the BORON datapath and its key schedule.
//   start     : load key_in and begin a schedule (honoured only when idle)
//   key_in    : 80-bit master key, sampled on an accepted start
//   advance   : datapath consumed the current round key; step to the next
//   key_round : current 64-bit round key (meaningful while rk_valid)
//   counter   : index of the current round key
//   rk_valid  : key_round/counter valid
//   busy      : schedule in progress
//   done      : one-cycle pulse after the last key is consumed
interface boron_key_schedule_if;
    logic        start;
    logic [79:0] key_in;
    logic        advance;
    logic [63:0] key_round;
    logic [4:0]  counter;
    logic        rk_valid;
    logic        busy;
    logic        done;

    modport slave (
        input  start, key_in, advance,
        output key_round, counter, rk_valid, busy, done
    );

    modport master (
        output start, key_in, advance,
        input  key_round, counter, rk_valid, busy, done
    );
endinterface

// File: rtl/boron_key_schedule.sv
// BORON key schedule: expands an 80-bit master key into NUM_RK 64-bit round
// keys, stepping one key per accepted advance strobe.
//   clk : system clock, all state on rising edge
//   rst : synchronous, active-high reset
//   bus : boron_key_schedule_if.slave (start/key_in/advance in,
//         key_round/counter/rk_valid/busy/done out)
module boron_key_schedule #(
    parameter int unsigned NUM_RK = 26,
    parameter int unsigned KEY_W  = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    boron_key_schedule_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);

    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
        4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
    };

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [4:0]         cnt_q, cnt_d;

    // Rotate left by 13, substitute the low nibble, then mix the round
    // index into bits 63:59.
    function automatic logic [KEY_W-1:0] key_update(
        input logic [KEY_W-1:0] k,
        input logic [4:0]       rc
    );
        logic [KEY_W-1:0] r;
        r          = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
        r[3:0]     = SBOX[r[3:0]];
        r[63:59]   = r[63:59] ^ rc;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.advance) begin
                    // The last key is consumed without updating, so key_q and
                    // cnt_q still show it while DONE is signalled.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        key_d = key_update(key_q, cnt_q);
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.key_round = key_q[63:0];
        bus.counter   = cnt_q;
        bus.rk_valid  = (state_q == RUN);
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
    end

endmodule

// File: doc/boron_key_schedule.md
Name: boron_key_schedule

Overview:
- Generates the BORON round keys from an 80-bit master key, one 64-bit round key per round.
- Feeds the round-key XOR stage in the cipher datapath (its `key_round` input) together with the 5-bit round counter.
- Sequential: the key register is updated in place, and the datapath controls stepping with an advance strobe.
- Produces 26 round keys (indices 0..25): 25 rounds plus final whitening.

Parameters:
- NUM_RK, 26, number of round keys produced per start (last index = NUM_RK-1).
- KEY_W, 80, master key width (only 80 is supported).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  load key_in and begin a schedule; honoured only in IDLE
- key_in  input  80  master key, sampled on an accepted start
- advance  input  1  datapath consumed current round key; step to next
- key_round  output  64  current round key = key_reg[63:0]
- counter  output  5  index of current round key, 0..25
- rk_valid  output  1  key_round/counter valid (high only in RUN)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last key is consumed

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clock edge, takes priority over everything):
  - key_reg=0, counter=0, state=IDLE.
  - key_round=0, rk_valid=0, busy=0, done=0.
  - Reset mid-RUN abandons the schedule; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> key_reg<=key_in, counter<=0, go RUN.
  - Next cycle: rk_valid=1, key_round=key_in[63:0], counter=0. Load-to-first-key latency is 1 cycle.
  - advance is ignored in IDLE.
- RUN, advance=1 and counter<NUM_RK-1:
  - key_reg<=update(key_reg, counter), counter<=counter+1.
  - The new key appears the next cycle; there is no bubble.
- RUN, advance=1 and counter==NUM_RK-1:
  - Go DONE; rk_valid<=0; key_reg and counter hold.
- RUN, advance=0: everything holds. A stall of any length is allowed.
- start in RUN or DONE is ignored; the key is not reloaded.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- update(K, rc) on the 80-bit register, applied in this order:
  1. K = K rotated left by 13 (bit i moves to bit (i+13) mod 80).
  2. K[3:0] = S(K[3:0]), with S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6} for input 0..F.
  3. K[63:59] = K[63:59] XOR rc. rc is the 5-bit counter value before increment, LSB at bit 59.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- key_round is driven from key_reg in every state; it is meaningful only when rk_valid=1.

Test Plan:
- Reset then start, key_in=0 -> 1 cycle later rk_valid=1, counter=0, key_round=0x0000000000000000.
- Continue the all-zero key with advance=1 -> counter=1: key_round=0x000000000000000E. Counter=2: key_round=0x080000000001C00E.
- Any key, advance held high for 26 cycles -> counter steps 0..25, then rk_valid falls and done=1 for exactly one cycle, then busy=0. Total RUN cycles = 26.
- Stall: deassert advance for 5 cycles at counter=7 -> key_round and counter constant; resumes with key 8 identical to a no-stall run.
- Start pulsed at counter=10 with a different key_in -> ignored; sequence matches a run without the pulse.
- rst=1 at counter=12 -> next cycle all outputs 0 and IDLE, no done. A new start then produces key 0 = new key_in[63:0].
